bus_master_ctrl: RTL and testbench

Master-side bus access sequencer placed between a pipeline memory stage and one master channel of the shared bus. It turns a single-cycle pipeline read/write request into the full bus handshake: request, wait for grant, one-cycle address strobe, wait for slave ready, then release. It captures read data, stalls the requester while the access is in flight, and aborts with an error pulse if the slave never answers.

---
 rtl/bus_master_ctrl.sv | 155 +++++++++++++++
 tb/tb_bus_master_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_ctrl.sv
// Master-side bus access sequencer: turns a pipeline read/write request into the
// request / grant / strobe / ready handshake, with read capture and slave timeout.
module bus_master_ctrl #(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {StIdle, StReq, StAccess, StWait} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_as_q, bus_as_d;
  logic              bus_rw_q, bus_rw_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic start, complete, abort;

  // A request arriving in the done cycle is ignored to give one turnaround cycle.
  assign start    = (state_q == StIdle) & req & ~flush & ~done_q;
  assign complete = ((state_q == StAccess) | (state_q == StWait)) & ~bus_rdy_;
  assign abort    = TO_EN & (state_q == StWait) & bus_rdy_ & (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bus_req_q     <= 1'b1;
      bus_as_q      <= 1'b1;
      bus_rw_q      <= 1'b1;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      rd_data_q     <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bus_req_q     <= bus_req_d;
      bus_as_q      <= bus_as_d;
      bus_rw_q      <= bus_rw_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_data_q     <= rd_data_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StReq;
      end
      StReq: begin
        // Flush wins over a grant sampled on the same edge.
        if (flush)           state_d = StIdle;
        else if (!bus_grnt_) state_d = StAccess;
      end
      StAccess: begin
        state_d = complete ? StIdle : StWait;
      end
      StWait: begin
        if (complete || abort) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_req_d     = 1'b1;
    bus_as_d      = 1'b1;
    bus_rw_d      = bus_rw_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_data_d     = rd_data_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    cnt_d         = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          bus_req_d     = 1'b0;
          bus_rw_d      = rw;
          bus_addr_d    = addr;
          bus_wr_data_d = wr_data;
        end
      end
      StReq: begin
        if (!flush) begin
          bus_req_d = 1'b0;
          if (!bus_grnt_) begin
            bus_as_d = 1'b0;
            cnt_d    = '0;
          end
        end
      end
      StAccess, StWait: begin
        if (complete) begin
          done_d = 1'b1;
          if (bus_rw_q) rd_data_d = bus_rd_data;
        end else if (abort) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end else begin
          bus_req_d = 1'b0;
          if (state_q == StWait && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign busy        = ~reset & ((state_q != StIdle) | start);
  assign bus_req_    = bus_req_q;
  assign bus_as_     = bus_as_q;
  assign bus_rw      = bus_rw_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;
  assign rd_data     = rd_data_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Directed bench for bus_master_ctrl: a per-cycle vector table plus hand-written
// sequences for delayed grant/write, timeout and reset during WAIT.
module tb_bus_master_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, rw, flush;
  logic [29:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        busy, done, err;
  logic        bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data, bus_rd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_master_ctrl #(.ADDR_W(30), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .rw(rw), .wr_data(wr_data),
    .flush(flush), .rd_data(rd_data), .busy(busy), .done(done), .err(err),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr), .bus_as_(bus_as_),
    .bus_rw(bus_rw), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .bus_rdy_(bus_rdy_)
  );

  typedef struct packed {
    logic        req, rw, flush, gnt_n, rdy_n;
    logic [29:0] addr;
    logic [31:0] rdat;
    logic        e_req_n, e_as_n, e_done, e_err, e_busy, e_rw;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic w, input logic f, input logic g,
                        input logic y);
    req = r; rw = w; flush = f; bus_grnt_ = g; bus_rdy_ = y;
  endtask

  initial begin
    // req rw fl gnt rdy addr rdat | req_ as_ done err busy rw rd
    vecs[0]  = '{1,1,0,0,0,30'h100,32'hDEADBEEF, 1,1,0,0,1,1,32'h0};
    vecs[1]  = '{1,1,0,0,0,30'h100,32'hDEADBEEF, 0,1,0,0,1,1,32'h0};
    vecs[2]  = '{1,1,0,0,0,30'h100,32'hDEADBEEF, 0,0,0,0,1,1,32'h0};
    vecs[3]  = '{1,1,0,0,0,30'h200,32'hCAFEF00D, 1,1,1,0,0,1,32'hDEADBEEF};
    vecs[4]  = '{1,1,0,0,0,30'h200,32'hCAFEF00D, 1,1,0,0,1,1,32'hDEADBEEF};
    vecs[5]  = '{1,1,0,0,0,30'h200,32'hCAFEF00D, 0,1,0,0,1,1,32'hDEADBEEF};
    vecs[6]  = '{1,1,0,0,0,30'h200,32'hCAFEF00D, 0,0,0,0,1,1,32'hDEADBEEF};
    vecs[7]  = '{0,1,0,0,0,30'h200,32'hCAFEF00D, 1,1,1,0,0,1,32'hCAFEF00D};
    vecs[8]  = '{0,1,0,1,1,30'h0,  32'h0,        1,1,0,0,0,1,32'hCAFEF00D};
    vecs[9]  = '{1,1,0,1,1,30'h300,32'h0,        1,1,0,0,1,1,32'hCAFEF00D};
    vecs[10] = '{1,1,0,1,1,30'h300,32'h0,        0,1,0,0,1,1,32'hCAFEF00D};
    vecs[11] = '{1,1,1,1,1,30'h300,32'h0,        0,1,0,0,1,1,32'hCAFEF00D};
    vecs[12] = '{0,1,0,1,1,30'h300,32'h0,        1,1,0,0,0,1,32'hCAFEF00D};
    vecs[13] = '{1,1,0,1,1,30'h300,32'h0,        1,1,0,0,1,1,32'hCAFEF00D};
    vecs[14] = '{1,1,1,0,1,30'h300,32'h0,        0,1,0,0,1,1,32'hCAFEF00D};
    vecs[15] = '{0,1,0,1,1,30'h300,32'h0,        1,1,0,0,0,1,32'hCAFEF00D};
    vecs[16] = '{1,1,1,1,1,30'h300,32'h0,        1,1,0,0,0,1,32'hCAFEF00D};
    vecs[17] = '{0,1,0,1,1,30'h300,32'h0,        1,1,0,0,0,1,32'hCAFEF00D};

    // Reset with a pending request: busy must stay low.
    reset = 1'b1; set_in(1, 1, 0, 1, 1);
    addr = 30'h0; wr_data = 32'h0; bus_rd_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_req_n", {31'b0, bus_req_}, 32'd1);
    chk("rst_as_n", {31'b0, bus_as_}, 32'd1);
    chk("rst_rw", {31'b0, bus_rw}, 32'd1);
    chk("rst_addr", {2'b0, bus_addr}, 32'd0);
    chk("rst_wd", bus_wr_data, 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    chk("rst_done_err", {30'b0, done, err}, 32'd0);
    tick();
    reset = 1'b0; req = 1'b0;

    // Immediate reads back-to-back, then flush cases.
    for (int i = 0; i < 18; i++) begin
      set_in(vecs[i].req, vecs[i].rw, vecs[i].flush, vecs[i].gnt_n, vecs[i].rdy_n);
      addr = vecs[i].addr; bus_rd_data = vecs[i].rdat;
      @(negedge clk);
      chk($sformatf("v%0d_req_n", i), {31'b0, bus_req_}, {31'b0, vecs[i].e_req_n});
      chk($sformatf("v%0d_as_n", i),  {31'b0, bus_as_},  {31'b0, vecs[i].e_as_n});
      chk($sformatf("v%0d_done", i),  {31'b0, done},     {31'b0, vecs[i].e_done});
      chk($sformatf("v%0d_err", i),   {31'b0, err},      {31'b0, vecs[i].e_err});
      chk($sformatf("v%0d_busy", i),  {31'b0, busy},     {31'b0, vecs[i].e_busy});
      chk($sformatf("v%0d_rw", i),    {31'b0, bus_rw},   {31'b0, vecs[i].e_rw});
      chk($sformatf("v%0d_rd", i),    rd_data,           vecs[i].e_rd);
      if (i == 2) chk("v2_addr", {2'b0, bus_addr}, 32'h100);
      tick();
    end

    // Delayed grant (5 cycles) write, ready 3 cycles after the strobe.
    set_in(1, 0, 0, 1, 1);
    addr = 30'h3ABCDEF; wr_data = 32'h12345678; bus_rd_data = 32'h55555555;
    @(negedge clk);
    chk("w_idle_busy", {31'b0, busy}, 32'd1);
    chk("w_idle_req_n", {31'b0, bus_req_}, 32'd1);
    tick();
    addr = 30'h1111111; wr_data = 32'hFFFF0000;
    for (int k = 0; k < 7; k++) begin
      if (k == 5) bus_grnt_ = 1'b0;
      if (k == 6) bus_grnt_ = 1'b1;
      if (k == 8) bus_rdy_ = 1'b0;
      @(negedge clk);
      chk($sformatf("w%0d_req_n", k), {31'b0, bus_req_}, 32'd0);
      chk($sformatf("w%0d_as_n", k), {31'b0, bus_as_}, (k == 6) ? 32'd0 : 32'd1);
      chk($sformatf("w%0d_rw", k), {31'b0, bus_rw}, 32'd0);
      chk($sformatf("w%0d_addr", k), {2'b0, bus_addr}, 32'h3ABCDEF);
      chk($sformatf("w%0d_wd", k), bus_wr_data, 32'h12345678);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      if (k == 2) bus_rdy_ = 1'b0;
      @(negedge clk);
      chk($sformatf("ww%0d_as_n", k), {31'b0, bus_as_}, 32'd1);
      chk($sformatf("ww%0d_req_n", k), {31'b0, bus_req_}, 32'd0);
      chk($sformatf("ww%0d_done", k), {31'b0, done}, 32'd0);
      chk($sformatf("ww%0d_addr", k), {2'b0, bus_addr}, 32'h3ABCDEF);
      tick();
    end
    set_in(0, 0, 0, 1, 1);
    @(negedge clk);
    chk("w_done", {31'b0, done}, 32'd1);
    chk("w_err", {31'b0, err}, 32'd0);
    chk("w_req_n", {31'b0, bus_req_}, 32'd1);
    chk("w_rd_kept", rd_data, 32'hCAFEF00D);
    chk("w_busy", {31'b0, busy}, 32'd0);
    tick();
    @(negedge clk);
    chk("w_single_done", {31'b0, done}, 32'd0);
    tick();

    // Timeout with TIMEOUT=4: err six cycles after the strobe cycle.
    set_in(1, 1, 0, 0, 1);
    addr = 30'h55; bus_rd_data = 32'hBAD0BAD0;
    tick();
    @(negedge clk);
    chk("to_req_n", {31'b0, bus_req_}, 32'd0);
    tick();
    @(negedge clk);
    chk("to_as_n", {31'b0, bus_as_}, 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("to_w%0d_as_n", k), {31'b0, bus_as_}, 32'd1);
      chk($sformatf("to_w%0d_req_n", k), {31'b0, bus_req_}, 32'd0);
      chk($sformatf("to_w%0d_de", k), {30'b0, done, err}, 32'd0);
      tick();
    end
    req = 1'b0;
    @(negedge clk);
    chk("to_done_err", {30'b0, done, err}, 32'd3);
    chk("to_req_n_rel", {31'b0, bus_req_}, 32'd1);
    chk("to_rd_kept", rd_data, 32'hCAFEF00D);
    tick();
    @(negedge clk);
    chk("to_after", {30'b0, done, err}, 32'd0);
    tick();

    // Reset in the middle of WAIT.
    set_in(1, 1, 0, 0, 1);
    addr = 30'h77; wr_data = 32'hA5A5A5A5;
    repeat (3) tick();
    @(negedge clk);
    chk("rw_in_wait", {30'b0, bus_req_, bus_as_}, 32'd1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rw_busy_in_rst", {31'b0, busy}, 32'd0);
    tick();
    reset = 1'b0; set_in(0, 1, 0, 1, 0);
    @(negedge clk);
    chk("rw_req_as", {30'b0, bus_req_, bus_as_}, 32'd3);
    chk("rw_rw", {31'b0, bus_rw}, 32'd1);
    chk("rw_addr", {2'b0, bus_addr}, 32'd0);
    chk("rw_wd", bus_wr_data, 32'd0);
    chk("rw_rd", rd_data, 32'd0);
    chk("rw_done_err", {30'b0, done, err}, 32'd0);
    chk("rw_busy", {31'b0, busy}, 32'd0);
    tick();
    @(negedge clk);
    chk("rw_no_done", {30'b0, done, err}, 32'd0);
    chk("rw_idle_req_n", {31'b0, bus_req_}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
